perm_output_serializer: RTL and testbench

- Final stage of the perm datapath. Sits directly downstream of the permutation core.
- Accepts a finished 1600-bit Keccak state plus its 8-bit tag in a single pushin cycle, buffers up to two states, and emits each state as eight 200-bit beats on dout with a beat index on doutix.
- Decouples the core's single-cycle 1600-bit result from the chip's 200-bit output bus.

---
 rtl/perm_output_serializer.sv | 117 +++++++++++
 tb/tb_perm_output_serializer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/perm_output_serializer.sv
// Buffers up to DEPTH finished permutation states and streams each one out
// as NBEATS registered beats of W_BEAT bits, low beat first, tag held per state.
module perm_output_serializer #(
  parameter int W_STATE = 1600,
  parameter int W_BEAT  = 200,
  parameter int NBEATS  = 8,
  parameter int W_TAG   = 8,
  parameter int DEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pushin,
  input  logic [W_STATE-1:0]        din,
  input  logic [W_TAG-1:0]          tagin,
  output logic                      pushout,
  output logic [W_BEAT-1:0]         dout,
  output logic [$clog2(NBEATS)-1:0] doutix,
  output logic [W_TAG-1:0]          tagout,
  output logic                      overflow
);
  localparam int IXW = $clog2(NBEATS);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic [W_TAG-1:0]   tag;
    logic [W_STATE-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  state_t             state_q, state_d;
  logic [PW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IXW-1:0]     beat_q, beat_d;
  logic               ovf_q;
  logic               pop, push_ok, upd;
  entry_t             src;
  logic [W_BEAT-1:0]  dout_d;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push is accepted while full only when the head is leaving this cycle.
  assign pop     = (state_q == SEND) && (beat_q == IXW'(NBEATS - 1));
  assign push_ok = pushin && ((cnt_q < CW'(DEPTH)) || pop);
  assign cnt_d   = cnt_q + CW'(push_ok) - CW'(pop);
  assign rd_d    = pop ? inc(rd_q) : rd_q;
  assign wr_d    = push_ok ? inc(wr_q) : wr_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    upd     = 1'b0;
    src     = mem[rd_q];
    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          state_d = SEND;
          beat_d  = '0;
          upd     = 1'b1;
        end
      end
      SEND: begin
        if (!pop) begin
          beat_d = beat_q + 1'b1;
          upd    = 1'b1;
        end else if (cnt_d != '0) begin
          beat_d = '0;
          upd    = 1'b1;
          // With a single entry left, the next head is the state arriving now.
          src    = (push_ok && cnt_q == CW'(1)) ? entry_t'({tagin, din}) : mem[rd_d];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    dout_d = src.data[int'(beat_d)*W_BEAT +: W_BEAT];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= entry_t'({tagin, din});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      ovf_q   <= 1'b0;
      pushout <= 1'b0;
      dout    <= '0;
      tagout  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      pushout <= (state_d == SEND);
      if (pushin && !push_ok) ovf_q <= 1'b1;
      if (upd) begin
        dout   <= dout_d;
        tagout <= src.tag;
      end
    end
  end

  assign doutix   = beat_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_perm_output_serializer.sv
// Directed scenarios plus random pushes, every cycle scored against a
// queue-based model of the buffered states and the expected beat stream.
module tb_perm_output_serializer;
  localparam int W  = 1600;
  localparam int WB = 200;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pushin = 1'b0;
  logic [W-1:0]  din = '0;
  logic [7:0]    tagin = '0;
  logic          pushout;
  logic [WB-1:0] dout;
  logic [2:0]    doutix;
  logic [7:0]    tagout;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq_d[$];
  logic [7:0]   mq_t[$];
  bit           m_send;
  bit           m_ovf;
  int           m_beat;

  perm_output_serializer dut (
    .clk(clk), .reset(reset), .pushin(pushin), .din(din), .tagin(tagin),
    .pushout(pushout), .dout(dout), .doutix(doutix), .tagout(tagout),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq_d.delete();
    mq_t.delete();
    m_send = 0;
    m_ovf  = 0;
    m_beat = 0;
  endtask

  // One clock edge of behaviour: accept/drop, retire a finished state, pick next beat.
  task automatic model_step(input bit p, input logic [W-1:0] d, input logic [7:0] t);
    int nb;
    bit pop, acc;
    nb  = mq_d.size();
    pop = m_send && (m_beat == NB - 1);
    acc = p && (nb < 2 || pop);
    if (p && !acc) m_ovf = 1;
    if (pop) begin
      void'(mq_d.pop_front());
      void'(mq_t.pop_front());
    end
    if (acc) begin
      mq_d.push_back(d);
      mq_t.push_back(t);
    end
    if (m_send) begin
      if (!pop) m_beat++;
      else if (mq_d.size() > 0) m_beat = 0;
      else m_send = 0;
    end else if (nb > 0) begin
      m_send = 1;
      m_beat = 0;
    end
  endtask

  task automatic compare();
    logic [W-1:0] h;
    chk("pushout", pushout, m_send);
    chk("overflow", overflow, m_ovf);
    if (m_send) begin
      h = mq_d[0];
      chk("doutix", doutix, m_beat);
      chk("dout", dout, h[m_beat*WB +: WB]);
      chk("tagout", tagout, mq_t[0]);
    end
  endtask

  task automatic cycle(input bit p, input logic [W-1:0] d, input logic [7:0] t);
    pushin = p;
    din    = d;
    tagin  = t;
    @(posedge clk);
    model_step(p, d, t);
    #1 compare();
    @(negedge clk);
    pushin = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, '0, '0);
  endtask

  function automatic logic [W-1:0] mk(input int id);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NB; k++) r[k*WB +: 32] = id * 256 + k + 1;
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset();
    pushin = 0;
    #2 reset = 0;
    #1;
    chk("rst_pushout", pushout, 1'b0);
    chk("rst_doutix", doutix, 3'd0);
    chk("rst_overflow", overflow, 1'b0);
    model_reset();
    @(posedge clk);
    #3 reset = 1;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    #1 reset = 0;
    #1;
    chk("init_pushout", pushout, 1'b0);
    chk("init_dout", dout, '0);
    chk("init_doutix", doutix, 3'd0);
    chk("init_tagout", tagout, 8'h00);
    chk("init_overflow", overflow, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;

    // single state
    cycle(1, mk(0), 8'hA5);
    idle(12);
    // back-to-back
    cycle(1, mk(1), 8'h01);
    idle(2);
    cycle(1, mk(2), 8'h02);
    idle(20);
    // overflow: third push dropped
    cycle(1, mk(3), 8'h03);
    cycle(1, mk(4), 8'h04);
    cycle(1, mk(5), 8'h05);
    idle(25);
    chk("ovf_sticky", overflow, 1'b1);
    // async reset during beat 3 of a burst
    cycle(1, mk(6), 8'h06);
    idle(4);
    chk("mid_burst_ix", doutix, 3'd3);
    async_reset();
    idle(20);
    cycle(1, mk(7), 8'h07);
    idle(12);
    // push on pop with the buffer full
    cycle(1, mk(8), 8'h08);
    cycle(1, mk(9), 8'h09);
    idle(7);
    chk("pop_align_ix", doutix, 3'd7);
    chk("pop_align_vld", pushout, 1'b1);
    cycle(1, mk(10), 8'h0A);
    idle(25);
    chk("pop_push_no_ovf", overflow, 1'b0);
    // idle gap
    cycle(1, mk(11), 8'h0B);
    idle(20);
    cycle(1, mk(12), 8'h0C);
    idle(12);
    // random traffic, light then heavy
    for (int i = 0; i < 300; i++) cycle($urandom_range(0, 4) == 0, rnd(), 8'($urandom()));
    for (int i = 0; i < 300; i++) cycle($urandom_range(0, 1) == 0, rnd(), 8'($urandom()));
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
